// File: rtl/light_pkg.sv
// Shared definitions for the light_fade slice: key codes, channel state
// encoding and the ASCII-to-channel map.
package light_pkg;

  // Lowercase ASCII codes of the twelve note keys, in channel order.
  localparam logic [7:0] KEY_Z = 8'h7A;
  localparam logic [7:0] KEY_S = 8'h73;
  localparam logic [7:0] KEY_X = 8'h78;
  localparam logic [7:0] KEY_D = 8'h64;
  localparam logic [7:0] KEY_C = 8'h63;
  localparam logic [7:0] KEY_V = 8'h76;
  localparam logic [7:0] KEY_G = 8'h67;
  localparam logic [7:0] KEY_B = 8'h62;
  localparam logic [7:0] KEY_H = 8'h68;
  localparam logic [7:0] KEY_N = 8'h6E;
  localparam logic [7:0] KEY_J = 8'h6A;
  localparam logic [7:0] KEY_M = 8'h6D;

  // Channel state encoding; 2'd3 is unused and recovers to OFF.
  localparam logic [1:0] ST_OFF  = 2'd0;
  localparam logic [1:0] ST_ON   = 2'd1;
  localparam logic [1:0] ST_FADE = 2'd2;

  // Result of a key lookup: hit=0 means the code is not a note key.
  typedef struct packed {
    logic       hit;
    logic [3:0] idx;
  } key_map_t;

  // Map an ASCII code to its channel index.
  function automatic key_map_t key_to_index(input logic [7:0] key);
    key_map_t res;
    res.hit = 1'b1;
    res.idx = 4'd0;
    case (key)
      KEY_Z:   res.idx = 4'd0;
      KEY_S:   res.idx = 4'd1;
      KEY_X:   res.idx = 4'd2;
      KEY_D:   res.idx = 4'd3;
      KEY_C:   res.idx = 4'd4;
      KEY_V:   res.idx = 4'd5;
      KEY_G:   res.idx = 4'd6;
      KEY_B:   res.idx = 4'd7;
      KEY_H:   res.idx = 4'd8;
      KEY_N:   res.idx = 4'd9;
      KEY_J:   res.idx = 4'd10;
      KEY_M:   res.idx = 4'd11;
      default: begin
        res.hit = 1'b0;
        res.idx = 4'd0;
      end
    endcase
    return res;
  endfunction

endpackage

// File: rtl/light_channel.sv
// One note channel: OFF/ON/FADE state plus its brightness register.
module light_channel
  import light_pkg::*;
#(
  parameter int PWM_BITS = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                press_i,
  input  logic                release_i,
  input  logic                fade_tick_i,
  output logic [PWM_BITS-1:0] bright_o,
  output logic [1:0]          state_o
);

  localparam logic [PWM_BITS-1:0] BRIGHT_MAX  = {PWM_BITS{1'b1}};
  localparam logic [PWM_BITS-1:0] BRIGHT_ZERO = {PWM_BITS{1'b0}};
  localparam logic [PWM_BITS-1:0] BRIGHT_ONE  = PWM_BITS'(1);

  logic [1:0]          state_d, state_q;
  logic [PWM_BITS-1:0] bright_d, bright_q;

  // Next state: a press always wins, even over a fade tick on the same edge.
  always_comb begin
    state_d  = state_q;
    bright_d = bright_q;
    if (press_i) begin
      state_d  = ST_ON;
      bright_d = BRIGHT_MAX;
    end else begin
      case (state_q)
        ST_ON: begin
          if (release_i) begin
            state_d = ST_FADE;
          end else begin
            state_d = ST_ON;
          end
          bright_d = BRIGHT_MAX;
        end
        ST_FADE: begin
          if (fade_tick_i) begin
            bright_d = bright_q - BRIGHT_ONE;
            if (bright_q == BRIGHT_ONE) begin
              state_d = ST_OFF;
            end else begin
              state_d = ST_FADE;
            end
          end else begin
            state_d  = ST_FADE;
            bright_d = bright_q;
          end
        end
        ST_OFF: begin
          state_d  = ST_OFF;
          bright_d = BRIGHT_ZERO;
        end
        default: begin
          state_d  = ST_OFF;
          bright_d = BRIGHT_ZERO;
        end
      endcase
    end
  end

  // State and brightness registers; reset dominates any event.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_OFF;
      bright_q <= BRIGHT_ZERO;
    end else begin
      state_q  <= state_d;
      bright_q <= bright_d;
    end
  end

  assign bright_o = bright_q;
  assign state_o  = state_q;

endmodule

// File: rtl/light_fade.sv
// Keyboard-driven LED fader: key decode, shared fade prescaler, shared PWM
// counter and per-channel PWM output registers.
module light_fade
  import light_pkg::*;
#(
  parameter int NUM_NOTES = 12,
  parameter int PWM_BITS  = 8,
  parameter int FADE_DIV  = 65536
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 inValid,
  input  logic                 inRelease,
  input  logic [7:0]           inKey,
  output logic [NUM_NOTES-1:0] outLED,
  output logic                 outBusy
);

  localparam int PRE_W = (FADE_DIV > 1) ? $clog2(FADE_DIV) : 1;
  localparam logic [PRE_W-1:0]    PRE_LAST  = PRE_W'(FADE_DIV - 1);
  localparam logic [PRE_W-1:0]    PRE_ZERO  = {PRE_W{1'b0}};
  localparam logic [PRE_W-1:0]    PRE_ONE   = PRE_W'(1);
  localparam logic [PWM_BITS-1:0] PWM_ZERO  = {PWM_BITS{1'b0}};
  localparam logic [PWM_BITS-1:0] PWM_ONE   = PWM_BITS'(1);
  localparam logic [NUM_NOTES-1:0] LED_ZERO = {NUM_NOTES{1'b0}};

  key_map_t             key_map_s;
  logic                 key_hit_s;
  logic [NUM_NOTES-1:0] press_s;
  logic [NUM_NOTES-1:0] release_s;
  logic                 fade_tick_s;

  logic [PRE_W-1:0]     pre_d, pre_q;
  logic [PWM_BITS-1:0]  pwm_d, pwm_q;
  logic [NUM_NOTES-1:0] led_d, led_q;
  logic                 busy_d, busy_q;

  logic [PWM_BITS-1:0]  bright_s [NUM_NOTES];
  logic [1:0]           state_s  [NUM_NOTES];

  // Decode the key event into one-hot press/release strobes; keys beyond
  // NUM_NOTES are dropped here so the channels never see them.
  always_comb begin
    key_map_s = key_to_index(inKey);
    key_hit_s = key_map_s.hit && (int'(key_map_s.idx) < NUM_NOTES);
    press_s   = LED_ZERO;
    release_s = LED_ZERO;
    for (int i = 0; i < NUM_NOTES; i++) begin
      if (inValid && key_hit_s && (int'(key_map_s.idx) == i)) begin
        press_s[i]   = ~inRelease;
        release_s[i] = inRelease;
      end else begin
        press_s[i]   = 1'b0;
        release_s[i] = 1'b0;
      end
    end
  end

  // Free-running prescaler and PWM counter; the tick fires on the terminal count.
  always_comb begin
    fade_tick_s = (pre_q == PRE_LAST);
    if (fade_tick_s) begin
      pre_d = PRE_ZERO;
    end else begin
      pre_d = pre_q + PRE_ONE;
    end
    pwm_d = pwm_q + PWM_ONE;
  end

  // Per-channel PWM compare and the any-channel-active flag.
  always_comb begin
    led_d  = LED_ZERO;
    busy_d = 1'b0;
    for (int i = 0; i < NUM_NOTES; i++) begin
      led_d[i] = (pwm_q < bright_s[i]);
      busy_d   = busy_d | (state_s[i] != ST_OFF);
    end
  end

  // Shared counters and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      pre_q  <= PRE_ZERO;
      pwm_q  <= PWM_ZERO;
      led_q  <= LED_ZERO;
      busy_q <= 1'b0;
    end else begin
      pre_q  <= pre_d;
      pwm_q  <= pwm_d;
      led_q  <= led_d;
      busy_q <= busy_d;
    end
  end

  for (genvar g = 0; g < NUM_NOTES; g++) begin : g_chan
    light_channel #(
      .PWM_BITS (PWM_BITS)
    ) u_chan (
      .clk         (clk),
      .rst         (rst),
      .press_i     (press_s[g]),
      .release_i   (release_s[g]),
      .fade_tick_i (fade_tick_s),
      .bright_o    (bright_s[g]),
      .state_o     (state_s[g])
    );
  end

  assign outLED  = led_q;
  assign outBusy = busy_q;

endmodule

// File: tb/tb_light_fade.sv
// Scoreboard bench for light_fade: stimulus queues cycle-stamped expectations,
// a monitor compares them against the outputs after each rising edge.
module tb_light_fade;
  import light_pkg::*;

  localparam int FDIV   = 2;
  localparam int PERIOD = 16;
  localparam int BMAX   = 15;
  localparam int NONE   = 32'h3FFF_FFFF;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0, in_release = 1'b0;
  logic [7:0]  in_key = 8'h00;
  logic        in_valid4 = 1'b0, in_release4 = 1'b0;
  logic [7:0]  in_key4 = 8'h00;
  logic [11:0] led12;
  logic        busy12;
  logic [3:0]  led4;
  logic        busy4;

  typedef struct {
    int          cyc;
    bit          sel4;
    logic [11:0] led;
    logic [11:0] mask;
    logic        busy;
    string       nm;
  } exp_t;

  exp_t sb_q[$];
  int   edge_n = 0;
  int   rel_edge = 0;
  int   n_vec = 0;
  int   n_err = 0;

  light_fade #(.NUM_NOTES(12), .PWM_BITS(4), .FADE_DIV(FDIV)) u_dut (
    .clk(clk), .rst(rst), .inValid(in_valid), .inRelease(in_release),
    .inKey(in_key), .outLED(led12), .outBusy(busy12)
  );

  light_fade #(.NUM_NOTES(4), .PWM_BITS(4), .FADE_DIV(FDIV)) u_dut4 (
    .clk(clk), .rst(rst), .inValid(in_valid4), .inRelease(in_release4),
    .inKey(in_key4), .outLED(led4), .outBusy(busy4)
  );

  always #5 clk = ~clk;

  always @(posedge clk) edge_n <= edge_n + 1;

  // Monitor: after each edge, compare every expectation stamped for it.
  always @(posedge clk) begin
    exp_t        e;
    logic [11:0] act_led;
    logic        act_busy;
    #2;
    while (sb_q.size() > 0 && sb_q[0].cyc <= edge_n) begin
      e = sb_q.pop_front();
      n_vec++;
      act_led  = e.sel4 ? {8'h00, led4} : led12;
      act_busy = e.sel4 ? busy4 : busy12;
      if (e.cyc < edge_n) begin
        n_err++;
        $display("FAIL %s cyc=%0d expectation stale at cyc=%0d", e.nm, e.cyc, edge_n);
      end else if (((act_led & e.mask) !== (e.led & e.mask)) || (act_busy !== e.busy)) begin
        n_err++;
        $display("FAIL %s cyc=%0d dut%0d got led=%03h busy=%b, required led=%03h busy=%b (mask %03h)",
                 e.nm, e.cyc, e.sel4 ? 4 : 12, act_led & e.mask, act_busy,
                 e.led & e.mask, e.busy, e.mask);
      end
    end
  end

  function automatic void push(input int cyc, input bit sel4, input logic [11:0] led,
                               input logic [11:0] mask, input logic busy, input string nm);
    exp_t e;
    int   i;
    e.cyc = cyc; e.sel4 = sel4; e.led = led; e.mask = mask; e.busy = busy; e.nm = nm;
    i = sb_q.size();
    while (i > 0 && sb_q[i-1].cyc > cyc) i--;
    sb_q.insert(i, e);
  endfunction

  // PWM counter value held after edge x (counts from 0 at the last reset edge).
  function automatic int pwm_at(input int x);
    return (x - rel_edge) % PERIOD;
  endfunction

  // Expected brightness after edge x for one channel: pressed at p,
  // released at r, pressed again at q.
  function automatic int bexp(input int x, input int p, input int r, input int q);
    int cnt;
    if (x < p) return 0;
    if (q != NONE && x >= q) return BMAX;
    if (r == NONE || x < r) return BMAX;
    cnt = 0;
    for (int e = r + 1; e <= x; e++)
      if ((e - rel_edge) % FDIV == 0) cnt++;
    return (BMAX - cnt < 0) ? 0 : BMAX - cnt;
  endfunction

  task automatic send_ev(input bit sel4, input logic [7:0] key, input logic rel);
    if (sel4) begin
      in_valid4 = 1'b1; in_key4 = key; in_release4 = rel;
    end else begin
      in_valid = 1'b1; in_key = key; in_release = rel;
    end
    @(negedge clk);
    in_valid = 1'b0; in_release = 1'b0; in_valid4 = 1'b0; in_release4 = 1'b0;
  endtask

  task automatic do_reset(input int ncyc);
    int n;
    @(negedge clk);
    rst = 1'b1;
    n = edge_n;
    for (int k = 1; k <= ncyc; k++) push(n + k, 1'b0, 12'h000, 12'hFFF, 1'b0, "reset_hold");
    push(n + ncyc + 1, 1'b0, 12'h000, 12'hFFF, 1'b0, "reset_exit");
    push(n + ncyc + 1, 1'b1, 12'h000, 12'h00F, 1'b0, "reset_exit4");
    repeat (ncyc) @(negedge clk);
    rst = 1'b0;
    rel_edge = edge_n;
  endtask

  // Single-channel scenario on the 12-note DUT, starting from all channels OFF.
  task automatic chan_scn(input string nm, input int idx, input logic [7:0] key,
                          input int rel_delay, input int rep_ticks, input bit rep_on_tick,
                          input int ncheck);
    int n, p, r, q, cnt, e, b;
    @(negedge clk);
    n = edge_n;
    p = n + 1;
    r = (rel_delay > 0) ? p + rel_delay : NONE;
    q = NONE;
    if (rep_ticks >= 0) begin
      cnt = 0;
      e = r;
      while (q == NONE) begin
        e++;
        if ((e - rel_edge) % FDIV == 0) begin
          cnt++;
          if (rep_on_tick && cnt == rep_ticks + 1) q = e;
          else if (!rep_on_tick && cnt == rep_ticks) q = e + 1;
        end
      end
    end
    for (int m = p; m <= p + ncheck; m++) begin
      b = bexp(m - 1, p, r, q);
      push(m, 1'b0, (b != 0 && pwm_at(m - 1) < b) ? (12'h001 << idx) : 12'h000,
           12'hFFF, (b != 0), nm);
    end
    send_ev(1'b0, key, 1'b0);
    if (r != NONE) begin
      while (edge_n < r - 1) @(negedge clk);
      send_ev(1'b0, key, 1'b1);
    end
    if (q != NONE) begin
      while (edge_n < q - 1) @(negedge clk);
      send_ev(1'b0, key, 1'b0);
    end
    while (edge_n < p + ncheck) @(negedge clk);
  endtask

  // Event that must leave the selected DUT completely idle.
  task automatic ign_scn(input string nm, input bit sel4, input logic [7:0] key,
                         input logic rel, input int ncheck);
    int n;
    @(negedge clk);
    n = edge_n;
    for (int m = n + 1; m <= n + ncheck; m++)
      push(m, sel4, 12'h000, sel4 ? 12'h00F : 12'hFFF, 1'b0, nm);
    send_ev(sel4, key, rel);
    while (edge_n < n + ncheck) @(negedge clk);
  endtask

  initial begin
    int n, p, s;

    do_reset(3);
    chan_scn("press_z_on", 0, KEY_Z, 0, -1, 1'b0, 20);

    do_reset(2);
    chan_scn("fade_x_off", 2, KEY_X, 1, -1, 1'b0, 40);

    do_reset(2);
    chan_scn("repress_c_at7", 4, KEY_C, 1, 8, 1'b0, 40);

    do_reset(2);
    chan_scn("press_v_on_tick", 5, KEY_V, 2, 3, 1'b1, 30);

    do_reset(2);
    ign_scn("ignore_A_press", 1'b0, 8'h41, 1'b0, 6);
    ign_scn("ignore_A_release", 1'b0, 8'h41, 1'b1, 6);
    ign_scn("ignore_m_narrow", 1'b1, KEY_M, 1'b0, 6);

    // Narrow DUT still honours an in-range key ('d' -> channel 3).
    @(negedge clk);
    p = edge_n + 1;
    push(p, 1'b1, 12'h000, 12'h00F, 1'b0, "narrow_d_before");
    push(p + 1, 1'b1, (pwm_at(p) != BMAX) ? 12'h008 : 12'h000, 12'h00F, 1'b1, "narrow_d_on");
    push(p + 2, 1'b1, (pwm_at(p + 1) != BMAX) ? 12'h008 : 12'h000, 12'h00F, 1'b1, "narrow_d_on");
    send_ev(1'b1, KEY_D, 1'b0);
    repeat (3) @(negedge clk);

    // Reset in the middle of a fade, with a press offered during reset.
    do_reset(2);
    @(negedge clk);
    n = edge_n;
    push(n + 5, 1'b0, 12'h000, 12'h000, 1'b1, "busy_before_rst");
    send_ev(1'b0, KEY_Z, 1'b0);
    send_ev(1'b0, KEY_M, 1'b0);
    send_ev(1'b0, KEY_Z, 1'b1);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    in_valid = 1'b1; in_key = KEY_S; in_release = 1'b0;
    s = edge_n + 1;
    push(s, 1'b0, 12'h000, 12'hFFF, 1'b0, "rst_mid_fade");
    push(s + 1, 1'b0, 12'h000, 12'hFFF, 1'b0, "rst_mid_fade");
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    rel_edge = edge_n;
    for (int m = rel_edge + 1; m <= rel_edge + 8; m++)
      push(m, 1'b0, 12'h000, 12'hFFF, 1'b0, "after_rst_idle");
    while (edge_n < rel_edge + 8) @(negedge clk);
    chan_scn("restart_m_fade", 11, KEY_M, 1, -1, 1'b0, 40);

    for (int k = 0; k < 100 && sb_q.size() > 0; k++) @(negedge clk);
    while (sb_q.size() > 0) begin
      exp_t e;
      e = sb_q.pop_front();
      n_vec++;
      n_err++;
      $display("FAIL %s cyc=%0d never checked (last edge %0d)", e.nm, e.cyc, edge_n);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
